// File: rtl/button_debouncer.sv
// Single-button debouncer: two-flop synchronizer, self-generated slow sample
// tick, press/release qualification over STABLE_TICKS agreeing samples and a
// long-press detector. Pulses are registered and last one clk_in cycle.
//
// state        | meaning
// -------------|-------------------------------------------------------------
// IDLE         | released, waiting for a first pressed sample
// PRESS_WAIT   | counting consecutive pressed samples toward acceptance
// PRESSED      | accepted press, counting hold samples toward LONG_TICKS
// LONG         | long press reported, hold counter frozen
// RELEASE_WAIT | counting consecutive released samples toward acceptance
module button_debouncer #(
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 600,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic long_pulse,
  output logic release_pulse,
  output logic sample_tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS);
  localparam logic [SW-1:0] STABLE_ONE = SW'(1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_TICKS);
  localparam logic          PIN_IDLE   = ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          btn_s;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_inc;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_inc;
  logic          long_flag;

  // Two-flop synchronizer, parked at the idle pin level during reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{PIN_IDLE}};
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  assign btn_s = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // Free-running sample divider; the tick is the terminal count itself.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign sample_tick = (tick_cnt == TICK_LAST);
  assign stable_inc  = stable_cnt + SW'(1);
  assign hold_inc    = hold_cnt + HW'(1);

  // Debounce FSM; only advances on sample ticks, pulses clear every cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      stable_cnt    <= '0;
      hold_cnt      <= '0;
      long_flag     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      release_pulse <= 1'b0;
      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (btn_s) begin
              stable_cnt <= STABLE_ONE;
              if (STABLE_MAX == STABLE_ONE) begin
                state       <= PRESSED;
                hold_cnt    <= '0;
                long_flag   <= 1'b0;
                press_pulse <= 1'b1;
                btn_level   <= 1'b1;
              end else begin
                state <= PRESS_WAIT;
              end
            end
          end
          PRESS_WAIT: begin
            if (btn_s) begin
              stable_cnt <= stable_inc;
              if (stable_inc == STABLE_MAX) begin
                state       <= PRESSED;
                hold_cnt    <= '0;
                long_flag   <= 1'b0;
                press_pulse <= 1'b1;
                btn_level   <= 1'b1;
              end
            end else begin
              state      <= IDLE;
              stable_cnt <= '0;
            end
          end
          PRESSED, LONG: begin
            if (btn_s) begin
              // Hold only advances in PRESSED and saturates at HOLD_MAX.
              if (state == PRESSED && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_inc;
                if (hold_inc == HOLD_MAX) begin
                  state      <= LONG;
                  long_flag  <= 1'b1;
                  long_pulse <= 1'b1;
                end
              end
            end else begin
              stable_cnt <= STABLE_ONE;
              if (STABLE_MAX == STABLE_ONE) begin
                state         <= IDLE;
                release_pulse <= 1'b1;
                btn_level     <= 1'b0;
              end else begin
                state <= RELEASE_WAIT;
              end
            end
          end
          RELEASE_WAIT: begin
            if (btn_s) begin
              // A bounce resumes the hold without restarting the long count.
              state <= long_flag ? LONG : PRESSED;
            end else begin
              stable_cnt <= stable_inc;
              if (stable_inc == STABLE_MAX) begin
                state         <= IDLE;
                release_pulse <= 1'b1;
                btn_level     <= 1'b0;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
